// File: rtl/rot_seq_ctrl_pkg.sv
// Shared types and constants for the rotate-sequence controller slice.
package rot_seq_ctrl_pkg;

  localparam int ROT_W = 4;  // rotator word width
  localparam int SEL_W = 2;  // rotator select width

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/rot_seq_ctrl_if.sv
// Job/result handshake plus the rotator hookup for rot_seq_ctrl.
interface rot_seq_ctrl_if #(parameter int REP_W = 4);
  import rot_seq_ctrl_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [ROT_W-1:0] in_data;
  logic [SEL_W-1:0] in_amt;
  logic [REP_W-1:0] in_reps;
  logic             out_valid;
  logic             out_ready;
  logic [ROT_W-1:0] out_data;
  logic             busy;
  logic [ROT_W-1:0] rot_w;
  logic             rot_s1;
  logic             rot_s0;
  logic [ROT_W-1:0] rot_out;

  // Controller side.
  modport slave (
    input  in_valid, in_data, in_amt, in_reps, out_ready, rot_out,
    output in_ready, out_valid, out_data, busy, rot_w, rot_s1, rot_s0
  );

  // Job source / result sink / rotator side.
  modport master (
    output in_valid, in_data, in_amt, in_reps, out_ready, rot_out,
    input  in_ready, out_valid, out_data, busy, rot_w, rot_s1, rot_s0
  );
endinterface

// File: rtl/rot_rep_counter.sv
// Loadable down-counter of remaining rotate steps, with a last-step flag.
module rot_rep_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         last
);

  // Load wins over decrement; decrement saturates at zero.
  always_ff @(posedge clk) begin
    if (rst)                   cnt <= '0;
    else if (load)             cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - W'(1);
  end

  assign last = (cnt == W'(1));

endmodule

// File: rtl/rot_seq_ctrl.sv
// Iterative rotate controller: applies amt for reps steps through an
// external combinational rotator, then holds the word for the consumer.
module rot_seq_ctrl
  import rot_seq_ctrl_pkg::*;
#(
  parameter int REP_W  = 4,
  parameter int DATA_W = 4   // must equal ROT_W
) (
  input  logic             clk,
  input  logic             rst,
  rot_seq_ctrl_if.slave    bus
);

  state_t             state;
  logic [DATA_W-1:0]  data_q;
  logic [SEL_W-1:0]   amt_q;
  logic [REP_W-1:0]   cnt_q;
  logic               cnt_last;
  logic               accept;

  assign accept = (state == IDLE) && bus.in_valid;

  rot_rep_counter #(.W(REP_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (bus.in_reps),
    .dec      (state == ROTATE),
    .cnt      (cnt_q),
    .last     (cnt_last)
  );

  // Control FSM and working register; reset beats any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      data_q <= '0;
      amt_q  <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          data_q <= bus.in_data;
          amt_q  <= bus.in_amt;
          state  <= (bus.in_reps != '0) ? ROTATE : DONE;
        end
        ROTATE: begin
          data_q <= bus.rot_out;
          if (cnt_last) state <= DONE;
        end
        DONE: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs depend on registers only.
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_data  = data_q;
  assign bus.rot_w     = data_q;
  assign bus.rot_s1    = amt_q[1];
  assign bus.rot_s0    = amt_q[0];

endmodule

// File: tb/tb_rot_seq_ctrl.sv
// Bench for rot_seq_ctrl: directed plan items plus randomized traffic,
// checked every cycle against a job-level model of the controller.
module tb_rot_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rot_seq_ctrl_if #(.REP_W(4)) bus();

  rot_seq_ctrl #(.REP_W(4), .DATA_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [3:0] rotr(input logic [3:0] w, input int n);
    logic [7:0] x;
    x = {w, w} >> (n % 4);
    return x[3:0];
  endfunction

  // External rotator sibling.
  assign bus.rot_out = rotr(bus.rot_w, int'({bus.rot_s1, bus.rot_s0}));

  int n_pass = 0;
  int n_tot  = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Job-level model: a job is original word + amount + steps done so far.
  bit         m_act, m_done;
  int         m_left, m_k;
  logic [3:0] m_d0;
  logic [1:0] m_amt;

  always @(posedge clk) begin
    if (rst) begin
      m_act = 0; m_done = 0; m_left = 0; m_k = 0; m_d0 = '0; m_amt = '0;
    end else if (!m_act) begin
      if (bus.in_valid) begin
        m_act = 1; m_d0 = bus.in_data; m_amt = bus.in_amt; m_k = 0;
        m_left = int'(bus.in_reps);
        m_done = (m_left == 0);
      end
    end else if (!m_done) begin
      m_k++; m_left--;
      if (m_left == 0) m_done = 1;
    end else if (bus.out_ready) begin
      m_act = 0; m_done = 0;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [3:0] w;
      w = rotr(m_d0, int'(m_amt) * m_k);
      chk("in_ready",  32'(bus.in_ready),  32'(!m_act));
      chk("out_valid", 32'(bus.out_valid), 32'(m_done));
      chk("busy",      32'(bus.busy),      32'(m_act));
      chk("out_data",  32'(bus.out_data),  32'(w));
      chk("rot_w",     32'(bus.rot_w),     32'(w));
      chk("rot_sel",   32'({bus.rot_s1, bus.rot_s0}), 32'(m_amt));
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (!bus.in_ready && t < 50) begin @(posedge clk); #1; t++; end
    chk("idle_wait", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic send(input logic [3:0] d, input logic [1:0] a, input logic [3:0] r);
    wait_idle();
    bus.in_valid = 1; bus.in_data = d; bus.in_amt = a; bus.in_reps = r;
    @(posedge clk); #1;
    bus.in_valid = 0;
  endtask

  // Returns edges after the accept edge until out_valid is seen.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic release_out();
    bus.out_ready = 1; @(posedge clk); #1; bus.out_ready = 0;
  endtask

  initial begin
    int lat;
    logic [3:0] held;
    bus.in_valid = 0; bus.in_data = '0; bus.in_amt = '0; bus.in_reps = '0;
    bus.out_ready = 0;

    // Reset then idle.
    rst = 1;
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    chk_en = 1;
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'd0);
    chk("rst_sel",       32'({bus.rot_s1, bus.rot_s0}), 32'd0);

    // 1000 >> 1 once.
    send(4'b1000, 2'd1, 4'd1);
    wait_out(lat);
    chk("lat_r1", 32'(lat), 32'd1);
    chk("res_r1", 32'(bus.out_data), 32'b0100);
    release_out();

    // 1011, amt 2 x3 -> net 2.
    send(4'b1011, 2'd2, 4'd3);
    chk("sel_rotate", 32'({bus.rot_s1, bus.rot_s0}), 32'b10);
    wait_out(lat);
    chk("lat_r3", 32'(lat), 32'd3);
    chk("res_r3", 32'(bus.out_data), 32'b1110);
    release_out();

    // reps=0 goes straight to DONE.
    send(4'b0110, 2'd3, 4'd0);
    wait_out(lat);
    chk("lat_r0", 32'(lat), 32'd0);
    chk("res_r0", 32'(bus.out_data), 32'b0110);
    release_out();

    // Backpressure with a competing job offered.
    send(4'b0011, 2'd1, 4'd2);
    wait_out(lat);
    chk("res_bp", 32'(bus.out_data), 32'b1100);
    held = bus.out_data;
    bus.in_valid = 1; bus.in_data = 4'b1111; bus.in_amt = 2'd0; bus.in_reps = 4'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_ready", 32'(bus.in_ready),  32'd0);
      chk("bp_data",  32'(bus.out_data),  32'(held));
    end
    bus.out_ready = 1;
    @(posedge clk); #1;
    bus.out_ready = 0;
    chk("bp_release_idle", 32'(bus.in_ready), 32'd1);
    chk("bp_release_busy", 32'(bus.busy),     32'd0);
    @(posedge clk); #1;
    bus.in_valid = 0;
    chk("bp_next_accept", 32'(bus.busy), 32'd1);
    wait_out(lat);
    chk("res_amt0", 32'(bus.out_data), 32'b1111);
    release_out();

    // Reset in the 3rd ROTATE cycle.
    send(4'b0001, 2'd1, 4'd15);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("mid_rst_ready", 32'(bus.in_ready),  32'd1);
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_data",  32'(bus.out_data),  32'd0);
    send(4'b0001, 2'd1, 4'd5);
    wait_out(lat);
    chk("lat_after_rst", 32'(lat), 32'd5);
    chk("res_after_rst", 32'(bus.out_data), 32'b1000);
    release_out();

    // Randomized traffic, backpressure and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      rst           = ($urandom_range(0, 149) == 0);
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_data   = 4'($urandom);
      bus.in_amt    = 2'($urandom);
      bus.in_reps   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 2))
                                                  : 4'($urandom_range(0, 15));
      bus.out_ready = ($urandom_range(0, 9) < 6);
    end
    @(posedge clk); #1;
    rst = 0; bus.in_valid = 0; bus.out_ready = 1;
    repeat (20) begin @(posedge clk); #1; end
    chk("drain_idle", 32'(bus.in_ready), 32'd1);

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/rot_seq_ctrl.md
Name: rot_seq_ctrl

Overview:
Upstream controller for the 4-bit combinational rotator stage.
- Accepts a rotate job {data, amount, repetitions} over a valid/ready handshake.
- Drives the rotator's data and select inputs, and feeds the rotator output back into its working register once per cycle.
- Presents the final word on a valid/ready output port.
- Net effect: rotate right by (amt*reps) mod 4, done iteratively through the shared rotator.

Parameters:
REP_W, 4, width of the repetition count; max reps = 2^REP_W-1
DATA_W, 4, word width; fixed at 4 to match the rotator, other values unsupported

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  job offered
in_ready  out  1  controller can accept a job
in_data  in  4  word to rotate
in_amt  in  2  rotate-right amount per step (0..3)
in_reps  in  REP_W  number of rotate steps
rot_w  out  4  to rotator data input
rot_s1  out  1  to rotator select MSB
rot_s0  out  1  to rotator select LSB
rot_out  in  4  from rotator output; combinational function of rot_w/rot_s1/rot_s0
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_data  out  4  result word
busy  out  1  high in ROTATE or DONE

Behaviour:
- One clock `clk`. Reset `rst` is synchronous and active-high.
- Rotator contract: with sel = {rot_s1, rot_s0}, rot_out = rot_w rotated right by sel.
  - Example: sel=1 gives out[3]=w[0], out[2]=w[3], out[1]=w[2], out[0]=w[1].
- Registers:
  - data_q[3:0] drives rot_w and out_data.
  - amt_q[1:0] drives {rot_s1, rot_s0}.
  - cnt_q[REP_W-1:0] is the remaining-step count.
  - state.
- Reset (rst=1 at an edge): state=IDLE, data_q=0, amt_q=0, cnt_q=0.
  - After reset: in_ready=1, out_valid=0, busy=0, out_data=0, rot_w=0, rot_s1=rot_s0=0.
- States: IDLE, ROTATE, DONE. All outputs are decoded from registers only; no input-to-output combinational path.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
  - busy = (state!=IDLE).
- IDLE: on in_valid & in_ready, load data_q=in_data, amt_q=in_amt, cnt_q=in_reps.
  - Next state is ROTATE if in_reps!=0, otherwise DONE.
  - in_valid without acceptance changes nothing.
- ROTATE: each cycle, data_q<=rot_out and cnt_q<=cnt_q-1.
  - When cnt_q==1 at the edge, next state is DONE; otherwise stay in ROTATE.
  - in_valid is ignored (in_ready=0).
- DONE: out_data=data_q and is held stable while out_ready=0.
  - On out_ready=1, next state is IDLE and data_q is held.
  - No new job is accepted in the same cycle as the output handshake; the earliest accept is the following cycle.
- Latency: job accepted at edge T, reps=N.
  - N>0: out_valid first high in the cycle after edge T+N.
  - N=0: out_valid high in the cycle after edge T.
- Throughput: one job per N+2 cycles minimum.
- amt=0 with N>0 still takes N cycles; the result equals the input.
- cnt_q never underflows, because ROTATE is never entered with cnt=0.
- rst asserted in any state, including mid-ROTATE or DONE with out_ready low, aborts the job and restores reset values at that edge. The partial result is discarded.
- rst has priority over every handshake in the same cycle.

Decomposition:
- Shared package holds:
  - the state enum (IDLE/ROTATE/DONE);
  - ROT_W=4;
  - a constant for rotate-select width = 2.
- The rotator stays an external sibling instance, connected at the parent level. It is not instantiated inside this block.
- One natural sub-module: rot_rep_counter, a loadable down-counter with a "last" flag (cnt==1). It is optional; inline is acceptable.

Test Plan:
- Reset then idle: rst high 2 cycles -> in_ready=1, out_valid=0, out_data=0, rot_s1=rot_s0=0.
- data=4'b1000, amt=1, reps=1 -> out_valid 2 cycles after accept, out_data=4'b0100.
- data=4'b1011, amt=2, reps=3 (net rotation 2) -> out_valid after 4 cycles, out_data=4'b1110; rot_s1=1, rot_s0=0 throughout ROTATE.
- data=4'b0110, amt=3, reps=0 -> out_valid the cycle after accept, out_data=4'b0110, no ROTATE cycles.
- Backpressure: complete a job with out_ready=0 for 5 cycles -> out_valid and out_data stable, in_ready=0; a new in_valid is not accepted until the cycle after out_ready=1.
- Reset mid-job: data=4'b0001, amt=1, reps=15, rst pulse in the 3rd ROTATE cycle -> next cycle IDLE, in_ready=1, out_valid=0, out_data=0; a following job completes correctly.
